// File: rtl/pmod_pkg.sv
// Shared definitions for the PMOD press counter: debounce FSM state
// encoding and the default timing constants for a 12 MHz board clock.
package pmod_pkg;

  localparam int unsigned CLK_HZ          = 32'd12000000;
  localparam int unsigned DEBOUNCE_CYCLES = 32'd120000;    // 10 ms at CLK_HZ
  localparam int unsigned TIMEOUT_CYCLES  = 32'd60000000;  // 5 s at CLK_HZ

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  // True when a 32-bit window counter sits on the last cycle of a window
  // that is 'window' cycles long.
  function automatic logic window_done(input logic [31:0] count,
                                       input int unsigned window);
    return count == (window - 32'd1);
  endfunction

endpackage

// File: rtl/pmod_debounce.sv
// Button conditioning: two-flop synchronizer followed by a four-state
// debounce FSM that emits one press pulse per stable press.
// Optional macro PMOD_PRESS_TIMEOUT_EN adds a 'released' status output
// that the top uses to run its idle timer.
module pmod_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = pmod_pkg::DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
`ifdef PMOD_PRESS_TIMEOUT_EN
  output logic released,
`endif
  output logic press
);

  import pmod_pkg::*;

  logic        s1;
  logic        s2;
  state_t      state;
  logic [31:0] cnt;
  logic        cnt_done;

  assign cnt_done = window_done(cnt, DEBOUNCE_CYCLES);

  // Bring the asynchronous button into the clock domain; idle level is high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= btn_n;
      s2 <= s1;
    end
  end

  // Debounce FSM: a level must hold for DEBOUNCE_CYCLES cycles to be accepted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= RELEASED;
      cnt   <= 32'd0;
    end else begin
      case (state)
        RELEASED: begin
          if (!s2) begin
            state <= PRESS_WAIT;
            cnt   <= 32'd0;
          end
        end
        PRESS_WAIT: begin
          if (s2) begin
            state <= RELEASED;
          end else if (cnt_done) begin
            state <= PRESSED;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        PRESSED: begin
          if (s2) begin
            state <= RELEASE_WAIT;
            cnt   <= 32'd0;
          end
        end
        RELEASE_WAIT: begin
          if (!s2) begin
            state <= PRESSED;
          end else if (cnt_done) begin
            state <= RELEASED;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        default: begin
          state <= RELEASED;
          cnt   <= 32'd0;
        end
      endcase
    end
  end

  // The pulse is decoded from registered state so the counter can advance on
  // the very edge that moves the FSM into PRESSED, which keeps the press
  // latency at DEBOUNCE_CYCLES+2 edges from the pin.
  assign press = (state == PRESS_WAIT) && !s2 && cnt_done;

`ifdef PMOD_PRESS_TIMEOUT_EN
  assign released = (state == RELEASED);
`endif

endmodule

// File: rtl/pmod_press_counter.sv
// PMOD press counter: counts debounced presses of an active-low button on
// pmod[1] and shows the count on led. pmod[0] is a synchronous active-low
// reset. Defining PMOD_PRESS_TIMEOUT_EN adds an idle timer that clears the
// count after TIMEOUT_CYCLES cycles with the button released.
module pmod_press_counter #(
  parameter int unsigned DEBOUNCE_CYCLES = pmod_pkg::DEBOUNCE_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES  = pmod_pkg::TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic [1:0] pmod,
  output logic [3:0] led
);

  import pmod_pkg::*;

  logic rst_n;
  logic btn_n;
  logic press;
  logic timeout;

  assign rst_n = pmod[0];
  assign btn_n = pmod[1];

  // Reject parameter values that would make the windows meaningless.
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("pmod_press_counter: DEBOUNCE_CYCLES must be at least 2");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("pmod_press_counter: TIMEOUT_CYCLES must be at least 2");
  end

`ifdef PMOD_PRESS_TIMEOUT_EN
  logic        released;
  logic [31:0] idle_cnt;

  pmod_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_n   (btn_n),
    .released(released),
    .press   (press)
  );

  assign timeout = released && window_done(idle_cnt, TIMEOUT_CYCLES);

  // Idle timer: runs only while the button rests released, restarts on expiry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idle_cnt <= 32'd0;
    end else if (!released || timeout) begin
      idle_cnt <= 32'd0;
    end else begin
      idle_cnt <= idle_cnt + 32'd1;
    end
  end
`else
  pmod_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk  (clk),
    .rst_n(rst_n),
    .btn_n(btn_n),
    .press(press)
  );

  assign timeout = 1'b0;
`endif

  // Press count: reset beats everything, a press beats a timeout clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      led <= 4'd0;
    end else if (press) begin
      led <= led + 4'd1;
    end else if (timeout) begin
      led <= 4'd0;
    end
  end

endmodule

// File: tb/tb_pmod_press_counter.sv
// Directed bench for pmod_press_counter with DEBOUNCE_CYCLES=4 and
// TIMEOUT_CYCLES=20. Inputs change and outputs are sampled on the falling
// edge; expected led values are worked out by hand from the pin timing.
// Building with PMOD_PRESS_TIMEOUT_EN selects the idle-timeout sequence.
module tb_pmod_press_counter;

  logic       clk;
  logic [1:0] pmod;
  logic [3:0] led;

  int checks   = 0;
  int failures = 0;

  pmod_press_counter #(
    .DEBOUNCE_CYCLES(4),
    .TIMEOUT_CYCLES (20)
  ) dut (
    .clk (clk),
    .pmod(pmod),
    .led (led)
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hold pmod at p for n rising edges, returning on the falling edge after the last.
  task automatic applyStimulus(input logic [1:0] p, input int n);
    pmod = p;
    repeat (n) @(negedge clk);
  endtask

  // Compare led against a hand-computed value.
  task automatic checkOutput(input string tag, input logic [3:0] expected);
    checks++;
    assert (led === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s: led=%0d expected=%0d", tag, led, expected);
    end
  endtask

  // Linear directed sequence.
  initial begin
    pmod = 2'b10;
    @(negedge clk);
    checkOutput("reset", 4'd0);

`ifndef PMOD_PRESS_TIMEOUT_EN
    applyStimulus(2'b11, 25);
    checkOutput("idle_25", 4'd0);
    applyStimulus(2'b11, 25);
    checkOutput("idle_50", 4'd0);

    // Clean press from edge k: led changes exactly on edge k+6.
    applyStimulus(2'b01, 6);
    checkOutput("press_k5", 4'd0);
    applyStimulus(2'b01, 1);
    checkOutput("press_k6", 4'd1);
    applyStimulus(2'b01, 4);
    checkOutput("press_held_k10", 4'd1);
    applyStimulus(2'b11, 10);
    checkOutput("release", 4'd1);

    // Bouncy contact never stays low long enough.
    applyStimulus(2'b01, 2);
    applyStimulus(2'b11, 1);
    applyStimulus(2'b01, 2);
    applyStimulus(2'b11, 10);
    checkOutput("bounce", 4'd1);

    // Four low cycles are one short of the five the pin path needs.
    applyStimulus(2'b01, 4);
    applyStimulus(2'b11, 10);
    checkOutput("short_4", 4'd1);

    // Five low cycles: press lands on edge j+6 even though the pin is back high.
    applyStimulus(2'b01, 5);
    applyStimulus(2'b11, 2);
    checkOutput("min_5", 4'd2);
    applyStimulus(2'b11, 10);

    // Fresh reset then 16 presses: 1..15 then wrap to 0.
    applyStimulus(2'b10, 1);
    checkOutput("reset_again", 4'd0);
    for (int i = 1; i <= 16; i++) begin
      applyStimulus(2'b01, 7);
      checkOutput($sformatf("wrap_%0d", i), 4'(i % 16));
      applyStimulus(2'b11, 8);
    end

    // Get a nonzero count, then reset while a press is pending.
    applyStimulus(2'b01, 7);
    checkOutput("pre_reset_press", 4'd1);
    applyStimulus(2'b11, 10);
    applyStimulus(2'b01, 3);
    applyStimulus(2'b00, 2);
    checkOutput("reset_mid_wait", 4'd0);
    applyStimulus(2'b01, 6);
    checkOutput("after_reset_r5", 4'd0);
    applyStimulus(2'b01, 1);
    checkOutput("after_reset_r6", 4'd1);
    applyStimulus(2'b11, 10);
    checkOutput("after_reset_release", 4'd1);

    // Reset on the exact edge the press would land: press is lost.
    applyStimulus(2'b01, 6);
    checkOutput("coincide_before", 4'd1);
    applyStimulus(2'b00, 1);
    checkOutput("coincide_reset", 4'd0);
    applyStimulus(2'b11, 10);
    checkOutput("coincide_after", 4'd0);
`else
    // Three presses, short releases between them.
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(2'b01, 7);
      checkOutput($sformatf("to_press_%0d", i), 4'(i));
      if (i < 3) applyStimulus(2'b11, 8);
    end
    // RELEASED from edge j+6; clear lands on edge j+26.
    applyStimulus(2'b11, 26);
    checkOutput("to_before_clear", 4'd3);
    applyStimulus(2'b11, 1);
    checkOutput("to_clear", 4'd0);

    // A press inside the window restarts the idle timer.
    applyStimulus(2'b01, 7);
    checkOutput("to_restart_p1", 4'd1);
    applyStimulus(2'b11, 21);
    checkOutput("to_restart_idle", 4'd1);
    applyStimulus(2'b01, 7);
    checkOutput("to_restart_p2", 4'd2);
    applyStimulus(2'b11, 26);
    checkOutput("to_restart_before", 4'd2);
    applyStimulus(2'b11, 1);
    checkOutput("to_restart_clear", 4'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
